// File: rtl/mem2axi_pkg.sv
// AXI4 encodings and helpers shared by the mem2axi bridge and its bench.
package mem2axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI size code for a full-width beat of the given byte count.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/mem2axi.sv
// RAM-style request port to single-beat AXI4 master bridge; one
// transaction outstanding, completion reported as a one-cycle rvalid_o pulse.
module mem2axi
    import mem2axi_pkg::*;
#(
    parameter int unsigned             AXI_ID_WIDTH   = 5,
    parameter int unsigned             AXI_ADDR_WIDTH = 64,
    parameter int unsigned             AXI_DATA_WIDTH = 64,
    parameter int unsigned             AXI_USER_WIDTH = 64,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // memory-style request port
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    // AXI4 write address
    output logic [AXI_ID_WIDTH-1:0]     aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]                  aw_len,
    output logic [2:0]                  aw_size,
    output logic [1:0]                  aw_burst,
    output logic                        aw_lock,
    output logic [3:0]                  aw_cache,
    output logic [2:0]                  aw_prot,
    output logic [3:0]                  aw_qos,
    output logic [3:0]                  aw_region,
    output logic [5:0]                  aw_atop,
    output logic [AXI_USER_WIDTH-1:0]   aw_user,
    output logic                        aw_valid,
    input  logic                        aw_ready,
    // AXI4 write data
    output logic [AXI_DATA_WIDTH-1:0]   w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    output logic                        w_last,
    output logic [AXI_USER_WIDTH-1:0]   w_user,
    output logic                        w_valid,
    input  logic                        w_ready,
    // AXI4 write response
    input  logic [AXI_ID_WIDTH-1:0]     b_id,
    input  logic [1:0]                  b_resp,
    input  logic                        b_valid,
    output logic                        b_ready,
    // AXI4 read address
    output logic [AXI_ID_WIDTH-1:0]     ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    output logic [7:0]                  ar_len,
    output logic [2:0]                  ar_size,
    output logic [1:0]                  ar_burst,
    output logic                        ar_lock,
    output logic [3:0]                  ar_cache,
    output logic [2:0]                  ar_prot,
    output logic [3:0]                  ar_qos,
    output logic [3:0]                  ar_region,
    output logic [AXI_USER_WIDTH-1:0]   ar_user,
    output logic                        ar_valid,
    input  logic                        ar_ready,
    // AXI4 read data
    input  logic [AXI_ID_WIDTH-1:0]     r_id,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]                  r_resp,
    input  logic                        r_last,
    input  logic                        r_valid,
    output logic                        r_ready
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  BEAT_SIZE  = axi_size(STRB_WIDTH);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

    state_e                    state, state_next;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      aw_valid_q, w_valid_q, ar_valid_q;
    logic                      rvalid_q, err_q;
    logic                      aw_done, w_done, b_err, r_err;

    // A channel counts as done once its valid has dropped or handshakes now.
    assign aw_done = !aw_valid_q || aw_ready;
    assign w_done  = !w_valid_q  || w_ready;
    assign b_err   = b_resp[1] | (b_id != AXI_ID);
    assign r_err   = r_resp[1] | ~r_last | (r_id != AXI_ID);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        gnt_o      = 1'b0;
        b_ready    = 1'b0;
        r_ready    = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) state_next = we_i ? WR_REQ : RD_REQ;
            end
            WR_REQ:  if (aw_done && w_done) state_next = WR_RESP;
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid) state_next = IDLE;
            end
            RD_REQ:  if (ar_valid_q && ar_ready) state_next = RD_RESP;
            RD_RESP: begin
                r_ready = 1'b1;
                if (r_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the request latches are reset too, so the bus never carries X after reset.
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (gnt_o) begin
                addr_q     <= addr_i;
                be_q       <= be_i;
                wdata_q    <= wdata_i;
                aw_valid_q <= we_i;
                w_valid_q  <= we_i;
                ar_valid_q <= !we_i;
            end
            if (aw_valid_q && aw_ready) aw_valid_q <= 1'b0;
            if (w_valid_q  && w_ready)  w_valid_q  <= 1'b0;
            if (ar_valid_q && ar_ready) ar_valid_q <= 1'b0;
            if (b_ready && b_valid) begin
                rvalid_q <= 1'b1;
                err_q    <= b_err;
            end
            if (r_ready && r_valid) begin
                rvalid_q <= 1'b1;
                err_q    <= r_err;
                rdata_q  <= r_data;
            end
        end
    end

    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    assign aw_id     = AXI_ID;
    assign aw_addr   = addr_q;
    assign aw_len    = 8'd0;
    assign aw_size   = BEAT_SIZE;
    assign aw_burst  = BURST_INCR;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_qos    = 4'd0;
    assign aw_region = 4'd0;
    assign aw_atop   = 6'd0;
    assign aw_user   = '0;
    assign aw_valid  = aw_valid_q;

    assign w_data    = wdata_q;
    assign w_strb    = be_q;
    assign w_last    = 1'b1;
    assign w_user    = '0;
    assign w_valid   = w_valid_q;

    assign ar_id     = AXI_ID;
    assign ar_addr   = addr_q;
    assign ar_len    = 8'd0;
    assign ar_size   = BEAT_SIZE;
    assign ar_burst  = BURST_INCR;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_qos    = 4'd0;
    assign ar_region = 4'd0;
    assign ar_user   = '0;
    assign ar_valid  = ar_valid_q;

endmodule

// File: tb/tb_mem2axi.sv
// Directed bench for mem2axi: a programmable AXI slave with a byte memory,
// a vector table of single transactions, and hand-written multi-cycle sequences.
module tb_mem2axi;
    import mem2axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [7:0]  be = '0;
    logic        gnt, rvalid_o, err_o;
    logic [63:0] rdata_o;

    logic [4:0]  aw_id, ar_id;
    logic [63:0] aw_addr, ar_addr, aw_user, w_user, ar_user, w_data;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_lock, ar_lock, w_last;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
    logic [5:0]  aw_atop;
    logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
    logic        b_valid = 1'b0, r_valid = 1'b0, r_last = 1'b1;
    logic [4:0]  b_id = '0, r_id = '0;
    logic [1:0]  b_resp = '0, r_resp = '0;
    logic [63:0] r_data = '0;

    mem2axi #(
        .AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
        .AXI_USER_WIDTH(64), .AXI_ID(5'd0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
        .aw_qos(aw_qos), .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- slave responder configuration ----------------
    int          cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0;
    logic [1:0]  cfg_resp = RESP_OKAY;
    logic [4:0]  cfg_id = '0;
    logic        cfg_r_last = 1'b1, cfg_from_mem = 1'b0;
    logic [63:0] cfg_r_data = '0;

    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit          aw_got, w_got, b_pend, r_pend, prev_aw, prev_w, prev_ar;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_rv = 0, viol = 0;
    logic [63:0] cap_aw_addr, cap_w_data, cap_ar_addr, r_data_q;
    logic [7:0]  cap_w_strb, cap_aw_len, cap_ar_len;
    logic [2:0]  cap_aw_size, cap_ar_size;
    logic [1:0]  cap_aw_burst;
    logic [4:0]  cap_aw_id, cap_ar_id;
    logic        cap_w_last;
    logic [63:0] mem [logic [63:0]];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'd0;
    endfunction

    // Drives readies/responses after each falling edge, then records the
    // handshakes that the following rising edge will complete.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            {aw_got, w_got, b_pend, r_pend, prev_aw, prev_w, prev_ar} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        end else begin
            aw_ready = aw_valid && (aw_cnt >= cfg_aw_wait);
            w_ready  = w_valid  && (w_cnt  >= cfg_w_wait);
            ar_ready = ar_valid && (ar_cnt >= cfg_ar_wait);
            b_valid  = b_pend; b_resp = cfg_resp; b_id = cfg_id;
            r_valid  = r_pend; r_resp = cfg_resp; r_id = cfg_id;
            r_last   = cfg_r_last; r_data = r_data_q;
            #1;
            if (prev_aw && !aw_valid) viol++;
            if (prev_w  && !w_valid)  viol++;
            if (prev_ar && !ar_valid) viol++;
            if (aw_got && aw_valid)   viol++;
            if (w_got  && w_valid)    viol++;
            prev_aw = aw_valid && !aw_ready;
            prev_w  = w_valid  && !w_ready;
            prev_ar = ar_valid && !ar_ready;
            if (aw_valid && aw_ready) begin
                cap_aw_addr = aw_addr; cap_aw_len = aw_len; cap_aw_size = aw_size;
                cap_aw_burst = aw_burst; cap_aw_id = aw_id;
                n_aw++; aw_got = 1; aw_cnt = 0;
            end else if (aw_valid) aw_cnt++;
            if (w_valid && w_ready) begin
                cap_w_data = w_data; cap_w_strb = w_strb; cap_w_last = w_last;
                n_w++; w_got = 1; w_cnt = 0;
            end else if (w_valid) w_cnt++;
            if (ar_valid && ar_ready) begin
                cap_ar_addr = ar_addr; cap_ar_len = ar_len; cap_ar_size = ar_size; cap_ar_id = ar_id;
                n_ar++; ar_cnt = 0; r_pend = 1;
                r_data_q = cfg_from_mem ? mem_rd(ar_addr) : cfg_r_data;
            end else if (ar_valid) ar_cnt++;
            if (b_valid && b_ready) begin b_pend = 0; n_b++; end
            if (r_valid && r_ready) begin r_pend = 0; n_r++; end
            if (aw_got && w_got) begin
                logic [63:0] mv;
                mv = mem_rd(cap_aw_addr);
                for (int i = 0; i < 8; i++)
                    if (cap_w_strb[i]) mv[i*8 +: 8] = cap_w_data[i*8 +: 8];
                mem[cap_aw_addr] = mv;
                b_pend = 1; aw_got = 0; w_got = 0;
            end
            if (rvalid_o) n_rv++;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        int          aw_wait, w_wait, ar_wait;
        logic [1:0]  resp;
        logic [4:0]  rsp_id;
        logic        r_last;
        logic        from_mem;
        logic [63:0] r_data;
        int          exp_lat;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat, aw0, w0, b0, ar0, r0;
        string t;
        v = vecs[idx];
        t = $sformatf("v%0d", idx);
        aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
        cfg_aw_wait = v.aw_wait; cfg_w_wait = v.w_wait; cfg_ar_wait = v.ar_wait;
        cfg_resp = v.resp; cfg_id = v.rsp_id; cfg_r_last = v.r_last;
        cfg_from_mem = v.from_mem; cfg_r_data = v.r_data;
        @(negedge clk);
        req = 1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
        #2 check({t, " gnt"}, 64'(gnt), 64'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req = 0;
            #2;
            if (rvalid_o) begin lat = k; break; end
        end
        check({t, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({t, " err"}, 64'(err_o), 64'(v.exp_err));
        check({t, " rdata"}, rdata_o, v.exp_rdata);
        if (v.we) begin
            check({t, " aw_addr"}, cap_aw_addr, v.addr);
            check({t, " w_data"}, cap_w_data, v.wdata);
            check({t, " w_strb"}, 64'(cap_w_strb), 64'(v.be));
            check({t, " aw len/size/burst/id/last"},
                  {cap_aw_len, cap_aw_size, cap_aw_burst, cap_aw_id, cap_w_last},
                  {8'd0, 3'd3, BURST_INCR, 5'd0, 1'b1});
            check({t, " aw/w/b count"}, 64'((n_aw - aw0) * 100 + (n_w - w0) * 10 + (n_b - b0)), 64'd111);
        end else begin
            check({t, " ar_addr"}, cap_ar_addr, v.addr);
            check({t, " ar len/size/id"}, {cap_ar_len, cap_ar_size, cap_ar_id}, {8'd0, 3'd3, 5'd0});
            check({t, " ar/r count"}, 64'((n_ar - ar0) * 10 + (n_r - r0)), 64'd11);
        end
        @(negedge clk);
        #2 check({t, " rvalid single pulse"}, 64'(rvalid_o), 64'd0);
    endtask

    int lat, nrv0, nar0;

    initial begin
        //             we    addr              wdata                  be     aw w  ar resp         id    last mem   r_data        lat err   exp_rdata
        vecs[0]  = '{1'b1, 64'h9000_0004, 64'hABCD,              8'hFF, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b0, 64'h0,     3, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 64'h9000_0004, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b1, 64'h0,     3, 1'b0, 64'hABCD};
        vecs[2]  = '{1'b1, 64'h9000_0010, 64'h1122334455667788,  8'h0F, 4, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b0, 64'h0,     7, 1'b0, 64'hABCD};
        vecs[3]  = '{1'b1, 64'h9000_0018, 64'hCAFEF00D_12345678, 8'hF0, 0, 3, 0, RESP_OKAY,   5'd0, 1'b1, 1'b0, 64'h0,     6, 1'b0, 64'hABCD};
        vecs[4]  = '{1'b1, 64'h9000_0020, 64'hDEAD,              8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b0, 64'h0,     3, 1'b0, 64'hABCD};
        vecs[5]  = '{1'b1, 64'h9000_0028, 64'h5A5A,              8'hFF, 0, 0, 0, RESP_SLVERR, 5'd0, 1'b1, 1'b0, 64'h0,     3, 1'b1, 64'hABCD};
        vecs[6]  = '{1'b1, 64'h9000_0028, 64'hA5A5,              8'hFF, 0, 0, 0, RESP_EXOKAY, 5'd0, 1'b1, 1'b0, 64'h0,     3, 1'b0, 64'hABCD};
        vecs[7]  = '{1'b1, 64'h9000_0028, 64'h3C3C,              8'hFF, 0, 0, 0, RESP_OKAY,   5'd3, 1'b1, 1'b0, 64'h0,     3, 1'b1, 64'hABCD};
        vecs[8]  = '{1'b0, 64'h9000_0030, 64'h0,                 8'h00, 0, 0, 0, RESP_DECERR, 5'd0, 1'b1, 1'b0, 64'h5555,  3, 1'b1, 64'h5555};
        vecs[9]  = '{1'b0, 64'h9000_0030, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd1, 1'b1, 1'b0, 64'h7777,  3, 1'b1, 64'h7777};
        vecs[10] = '{1'b0, 64'h9000_0030, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b0, 1'b0, 64'h8888,  3, 1'b1, 64'h8888};
        vecs[11] = '{1'b0, 64'h9000_0038, 64'h0,                 8'h00, 0, 0, 2, RESP_OKAY,   5'd0, 1'b1, 1'b0, 64'h1234,  5, 1'b0, 64'h1234};
        vecs[12] = '{1'b0, 64'h9000_0010, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b1, 64'h0,     3, 1'b0, 64'h0000_0000_5566_7788};
        vecs[13] = '{1'b0, 64'h9000_0018, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b1, 64'h0,     3, 1'b0, 64'hCAFEF00D_0000_0000};
        vecs[14] = '{1'b0, 64'h9000_0020, 64'h0,                 8'h00, 0, 0, 0, RESP_OKAY,   5'd0, 1'b1, 1'b1, 64'h0,     3, 1'b0, 64'h0};

        // reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset rvalid/err/gnt", {rvalid_o, err_o, gnt}, 3'b000);
        check("reset rdata", rdata_o, 64'h0);
        check("reset valids/readies", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 5'b0);
        check("fixed zero fields",
              {aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop,
               ar_lock, ar_cache, ar_prot, ar_qos, ar_region}, 38'd0);
        check("user fields", aw_user | w_user | ar_user, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // back-to-back write then read with req held high
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_resp = RESP_OKAY;
        cfg_id = '0; cfg_r_last = 1'b1; cfg_from_mem = 1'b1;
        nrv0 = n_rv;
        @(negedge clk);
        req = 1; we = 1; addr = 64'h9000_0040; be = 8'hFF; wdata = 64'h0F0F_0F0F;
        #2 check("b2b first gnt", 64'(gnt), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) we = 0;
            #2;
            if (k == 2) check("b2b gnt low while busy", 64'(gnt), 64'd0);
        end
        check("b2b first rvalid at cycle 3", 64'(rvalid_o), 64'd1);
        check("b2b regrant with rvalid", 64'(gnt), 64'd1);
        lat = 0;
        for (int k = 4; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) req = 0;
            #2;
            if (rvalid_o) begin lat = k; break; end
        end
        check("b2b second rvalid cycle", 64'(lat), 64'd6);
        check("b2b read data", rdata_o, 64'h0F0F_0F0F);
        check("b2b err", 64'(err_o), 64'd0);
        @(negedge clk);
        #2 check("b2b completions", 64'(n_rv - nrv0), 64'd2);

        // request raised and dropped while busy is not latched
        cfg_aw_wait = 3; cfg_from_mem = 1'b0;
        nar0 = n_ar;
        @(negedge clk);
        req = 1; we = 1; addr = 64'h9000_0048; be = 8'hFF; wdata = 64'h1;
        @(negedge clk);
        req = 0;
        @(negedge clk);
        req = 1; we = 0;
        #2 check("busy req gnt", 64'(gnt), 64'd0);
        @(negedge clk);
        req = 0;
        repeat (8) @(negedge clk);
        #2 check("dropped req not latched", 64'(n_ar - nar0), 64'd0);

        // reset while aw_valid waits for aw_ready
        cfg_aw_wait = 20;
        nrv0 = n_rv;
        @(negedge clk);
        req = 1; we = 1; addr = 64'h9000_0050; be = 8'hFF; wdata = 64'h2;
        repeat (3) begin @(negedge clk); req = 0; end
        #2 check("aw_valid pending before reset", 64'(aw_valid), 64'd1);
        rst_n = 1'b0;
        #1 check("async drop of valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        check("rdata cleared by reset", rdata_o, 64'h0);
        repeat (2) @(negedge clk);
        #2 check("no rvalid in reset", 64'(rvalid_o), 64'd0);
        rst_n = 1'b1;
        run_vec(1);
        check("no spurious completion", 64'(n_rv - nrv0), 64'd1);

        check("handshake stability violations", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem2axi.md
Name: mem2axi

Overview:
- Bridge that turns a simple single-port memory request interface (req/gnt/we/addr/be/wdata → rvalid/rdata) into single-beat AXI4 master transactions.
- Performs the reverse conversion of axi2mem.
- Lets a CGRA or any test engine with a RAM-style port act as an initiator on a crossbar slave port.
- Allows one outstanding transaction at a time.

Parameters:
- AXI_ID_WIDTH, 5, ID width of the attached AXI_BUS.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width (power of two, ≥32).
- AXI_USER_WIDTH, 64, user width; user fields are driven to 0.
- AXI_ID, 0, constant ID placed on AW/AR and expected on B/R.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1=write, 0=read
- addr_i  in  AXI_ADDR_WIDTH  byte address, passed unmodified
- be_i  in  AXI_DATA_WIDTH/8  write byte enables → w_strb
- wdata_i  in  AXI_DATA_WIDTH  write data
- rvalid_o  out  1  one-cycle completion pulse (reads and writes)
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o, held until next read completion
- err_o  out  1  error flag, valid with rvalid_o
- axi_master_port  AXI_BUS.Master  —  AXI4 master side

Behaviour:
- One clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - gnt_o, rvalid_o, err_o = 0; rdata_o = 0.
  - aw_valid, w_valid, ar_valid, b_ready, r_ready = 0.
  - Latched request registers = 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - gnt_o = req_i (combinational); gnt_o is 0 in every other state.
  - On req_i & gnt_o: latch we/addr/be/wdata; go to WR_REQ if we_i, else RD_REQ.
- WR_REQ:
  - aw_valid and w_valid are both registered high from the cycle after grant.
  - Each valid drops individually on its own handshake (aw_valid&aw_ready, w_valid&w_ready); handshakes may occur in either order or the same cycle.
  - When both are done (flags aw_done/w_done), go to WR_RESP.
- WR_RESP:
  - b_ready = 1.
  - On b_valid: register rvalid_o=1 next cycle; err_o = b_resp[1] | (b_id != AXI_ID); go to IDLE.
- RD_REQ:
  - ar_valid held high until ar_ready, then go to RD_RESP.
- RD_RESP:
  - r_ready = 1.
  - On r_valid: register rdata_o = r_data; err_o = r_resp[1] | !r_last | (r_id != AXI_ID); rvalid_o=1 next cycle; go to IDLE.
- Valid signals never depend combinationally on ready, and are never withdrawn before their handshake (except by reset).
- Fixed AW/AR fields:
  - id = AXI_ID, len = 0, size = $clog2(AXI_DATA_WIDTH/8), burst = INCR.
  - lock, cache, prot, qos, region, atop, user = 0.
  - w_last = 1; w_strb = latched be.
- Latency with always-ready slave (grant at cycle 0): AW/W or AR handshake at cycle 1, B/R at cycle 2, rvalid_o at cycle 3.
- Back-to-back requests: a new grant is possible in the same cycle rvalid_o pulses, because the FSM is already in IDLE.
- be_i = 0 on a write is legal; w_strb = 0 is issued as-is.
- Reset mid-transaction:
  - All valids drop immediately; the FSM returns to IDLE; no rvalid_o is generated.
  - System-level reset of the slave side is the user's responsibility.
- req_i may drop while no grant has been given; no request is latched in that case.

Decomposition:
- FSM enum stays local to the module.
- AXI constants (BURST_INCR, RESP_OKAY/SLVERR) come from axi_pkg; no new package constants.
- No sub-module is natural: the block is a single FSM with datapath registers.

Test Plan:
1. Write, always-ready responder: req addr=0x9000_0004, wdata=0xABCD, be=0xFF → aw_addr=0x9000_0004, w_data=0xABCD, w_strb=0xFF, w_last=1, size=3, len=0; rvalid_o at cycle 3, err_o=0.
2. Read-back through xbar + axi2mem + test_ram_64 (addr 0x9000_0004 after scenario 1) → rvalid_o with rdata_o=0xABCD, err_o=0.
3. Backpressure: w_ready asserted 4 cycles before aw_ready → w_valid drops after its handshake, aw_valid held stable until aw_ready; exactly one B accepted; one rvalid_o.
4. Error responses:
   - b_resp=SLVERR → err_o=1.
   - r_resp=DECERR → err_o=1, rdata_o updated.
   - r_id=AXI_ID+1 → err_o=1.
5. Back-to-back: req_i held high for write then read → second gnt_o in the same cycle as first rvalid_o; total 2 completions in 6 cycles with a zero-wait responder.
6. Reset asserted while aw_valid=1 and aw_ready=0 → aw_valid=0 immediately (async); after release, gnt_o=1 on next req_i; no spurious rvalid_o.
